// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
//  Module   : pipe_ctrl_pkg
//  Purpose  : Shared types and constants for the pipeline stall/flush control.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_flush;
  } ctrl_t;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

`default_nettype wire

// File: rtl/load_use_detect.sv
// ============================================================================
//  Module   : load_use_detect
//  Purpose  : Combinational load-use hazard compare between ID sources and EX rd.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] i_id_rs1_addr,
  input  logic [4:0] i_id_rs2_addr,
  input  logic       i_id_uses_rs1,
  input  logic       i_id_uses_rs2,
  input  logic [4:0] i_ex_rd_addr,
  input  logic       i_ex_rd_wren,
  input  logic       i_ex_is_load,
  output logic       o_lu
);

  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_ld_wr;

  // x0 is hardwired, so a load targeting it never creates a dependency
  assign w_ld_wr   = i_ex_is_load & i_ex_rd_wren & (i_ex_rd_addr != REG_X0);
  assign w_rs1_hit = i_id_uses_rs1 & (i_id_rs1_addr == i_ex_rd_addr);
  assign w_rs2_hit = i_id_uses_rs2 & (i_id_rs2_addr == i_ex_rd_addr);
  assign o_lu      = w_ld_wr & (w_rs1_hit | w_rs2_hit);

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// ============================================================================
//  Module   : pipeline_ctrl
//  Purpose  : Pipeline register enables/flushes, memory-wait timeout, counters.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_uses_rs1_i,
  input  logic             id_uses_rs2_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic             ex_rd_wren_i,
  input  logic             ex_is_load_i,
  input  logic             ex_mispred_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             id_ex_en_o,
  output logic             ex_mem_en_o,
  output logic             mem_wb_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             mem_wb_flush_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] c_TIMEOUT = WAIT_W'(MEM_TIMEOUT);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;
  ctrl_t             w_ctrl;
  logic              w_lu;
  logic              w_mem_stall;
  logic              w_timeout;
  logic              w_mem_err;

  load_use_detect u_lu (
    .i_id_rs1_addr (id_rs1_addr_i),
    .i_id_rs2_addr (id_rs2_addr_i),
    .i_id_uses_rs1 (id_uses_rs1_i),
    .i_id_uses_rs2 (id_uses_rs2_i),
    .i_ex_rd_addr  (ex_rd_addr_i),
    .i_ex_rd_wren  (ex_rd_wren_i),
    .i_ex_is_load  (ex_is_load_i),
    .o_lu          (w_lu)
  );

  // An ack wins over a simultaneous timeout: the access did complete.
  assign w_timeout   = (r_state == MEM_WAIT) & ~mem_ack_i & (r_wait_cnt == c_TIMEOUT);
  assign w_mem_stall = (r_state == RUN) ? (mem_req_i & ~mem_ack_i)
                                        : (~mem_ack_i & (r_wait_cnt != c_TIMEOUT));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    case (r_state)
      RUN: begin
        if (mem_req_i && !mem_ack_i) begin
          w_state_nxt = MEM_WAIT;
          w_wait_nxt  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_ack_i || (r_wait_cnt == c_TIMEOUT)) begin
          w_state_nxt = RUN;
          w_wait_nxt  = '0;
        end else begin
          w_wait_nxt  = r_wait_cnt + WAIT_W'(1);
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_wait_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    w_ctrl.pc_en        = 1'b1;
    w_ctrl.if_id_en     = 1'b1;
    w_ctrl.id_ex_en     = 1'b1;
    w_ctrl.ex_mem_en    = 1'b1;
    w_ctrl.mem_wb_en    = 1'b1;
    w_ctrl.if_id_flush  = 1'b0;
    w_ctrl.id_ex_flush  = 1'b0;
    w_ctrl.mem_wb_flush = 1'b0;
    w_mem_err           = 1'b0;
    if (rst_i) begin
      w_ctrl.if_id_flush  = 1'b1;
      w_ctrl.id_ex_flush  = 1'b1;
      w_ctrl.mem_wb_flush = 1'b1;
    end else if (w_mem_stall) begin
      w_ctrl.pc_en        = 1'b0;
      w_ctrl.if_id_en     = 1'b0;
      w_ctrl.id_ex_en     = 1'b0;
      w_ctrl.ex_mem_en    = 1'b0;
      w_ctrl.mem_wb_flush = 1'b1;
    end else begin
      if (w_timeout) begin
        w_ctrl.mem_wb_flush = 1'b1;
        w_mem_err           = 1'b1;
      end
      if (ex_mispred_i) begin
        w_ctrl.if_id_flush = 1'b1;
        w_ctrl.id_ex_flush = 1'b1;
      end else if (w_lu) begin
        w_ctrl.pc_en       = 1'b0;
        w_ctrl.if_id_en    = 1'b0;
        w_ctrl.id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_ctrl.pc_en && !(&r_stall_cnt))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_ctrl.if_id_flush && !(&r_flush_cnt))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign pc_en_o        = w_ctrl.pc_en;
  assign if_id_en_o     = w_ctrl.if_id_en;
  assign id_ex_en_o     = w_ctrl.id_ex_en;
  assign ex_mem_en_o    = w_ctrl.ex_mem_en;
  assign mem_wb_en_o    = w_ctrl.mem_wb_en;
  assign if_id_flush_o  = w_ctrl.if_id_flush;
  assign id_ex_flush_o  = w_ctrl.id_ex_flush;
  assign mem_wb_flush_o = w_ctrl.mem_wb_flush;
  assign mem_err_o      = w_mem_err;
  assign stall_cnt_o    = r_stall_cnt;
  assign flush_cnt_o    = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// ============================================================================
//  Module   : tb_pipeline_ctrl
//  Purpose  : Directed self-checking bench for pipeline_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipeline_ctrl;

  localparam int unsigned MEM_TIMEOUT = 4;
  localparam int unsigned CNT_W       = 4;

  // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_f, id_ex_f, mem_wb_f, mem_err}
  localparam logic [8:0] c_V_IDLE  = 9'b11111_000_0;
  localparam logic [8:0] c_V_LU    = 9'b00111_010_0;
  localparam logic [8:0] c_V_MISP  = 9'b11111_110_0;
  localparam logic [8:0] c_V_MSTL  = 9'b00001_001_0;
  localparam logic [8:0] c_V_TOMIS = 9'b11111_111_1;
  localparam logic [8:0] c_V_RST   = 9'b11111_111_0;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       rs1, rs2, rd;
  logic             use1, use2, wren, isld, mispred, req, ack;
  logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic             if_id_fl, id_ex_fl, mem_wb_fl, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [8:0]       w_vec;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .id_rs1_addr_i  (rs1),
    .id_rs2_addr_i  (rs2),
    .id_uses_rs1_i  (use1),
    .id_uses_rs2_i  (use2),
    .ex_rd_addr_i   (rd),
    .ex_rd_wren_i   (wren),
    .ex_is_load_i   (isld),
    .ex_mispred_i   (mispred),
    .mem_req_i      (req),
    .mem_ack_i      (ack),
    .pc_en_o        (pc_en),
    .if_id_en_o     (if_id_en),
    .id_ex_en_o     (id_ex_en),
    .ex_mem_en_o    (ex_mem_en),
    .mem_wb_en_o    (mem_wb_en),
    .if_id_flush_o  (if_id_fl),
    .id_ex_flush_o  (id_ex_fl),
    .mem_wb_flush_o (mem_wb_fl),
    .mem_err_o      (mem_err),
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt)
  );

  assign w_vec = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                  if_id_fl, id_ex_fl, mem_wb_fl, mem_err};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    use1 = 1'b0; use2 = 1'b0; wren = 1'b0; isld = 1'b0;
    mispred = 1'b0; req = 1'b0; ack = 1'b0;
  endtask

  // lw x5 in EX, add x6,x5,x1 in ID
  task automatic lu_inputs();
    idle_inputs();
    isld = 1'b1; wren = 1'b1; rd = 5'd5;
    rs1 = 5'd5; rs2 = 5'd1; use1 = 1'b1; use2 = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    #1 check("reset_vec", 32'(w_vec), 32'(c_V_RST));
    check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    check("reset_flush_cnt", 32'(flush_cnt), 32'd0);
    rst = 1'b0;
    #1 check("idle", 32'(w_vec), 32'(c_V_IDLE));
    tick();

    lu_inputs();
    #1 check("lu_rs1", 32'(w_vec), 32'(c_V_LU));
    tick();
    isld = 1'b0;
    #1 check("lu_release", 32'(w_vec), 32'(c_V_IDLE));
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    tick();

    lu_inputs(); rd = 5'd0; rs1 = 5'd0;
    #1 check("lu_x0", 32'(w_vec), 32'(c_V_IDLE));
    lu_inputs(); use1 = 1'b0;
    #1 check("lu_rs1_unused", 32'(w_vec), 32'(c_V_IDLE));
    lu_inputs(); rs1 = 5'd7; rs2 = 5'd5;
    #1 check("lu_rs2", 32'(w_vec), 32'(c_V_LU));
    lu_inputs(); wren = 1'b0;
    #1 check("lu_nowren", 32'(w_vec), 32'(c_V_IDLE));

    lu_inputs(); mispred = 1'b1;
    #1 check("mispred_over_lu", 32'(w_vec), 32'(c_V_MISP));
    tick();
    idle_inputs();
    #1 check("misp_flush_cnt", 32'(flush_cnt), 32'd1);
    check("misp_stall_cnt", 32'(stall_cnt), 32'd1);

    req = 1'b1; ack = 1'b1;
    #1 check("mem_same_ack", 32'(w_vec), 32'(c_V_IDLE));
    tick();
    idle_inputs();
    check("mem_same_ack_cnt", 32'(stall_cnt), 32'd1);

    for (int i = 0; i < 3; i++) begin
      req = 1'b1; ack = 1'b0;
      #1 check($sformatf("mem_stall_%0d", i), 32'(w_vec), 32'(c_V_MSTL));
      tick();
    end
    ack = 1'b1;
    #1 check("mem_ack_cycle", 32'(w_vec), 32'(c_V_IDLE));
    tick();
    idle_inputs();
    #1 check("mem_back_run", 32'(w_vec), 32'(c_V_IDLE));
    check("mem_stall_cnt", 32'(stall_cnt), 32'd4);

    for (int i = 0; i < int'(MEM_TIMEOUT); i++) begin
      req = 1'b1; ack = 1'b0; mispred = 1'b1;
      #1 check($sformatf("to_stall_%0d", i), 32'(w_vec), 32'(c_V_MSTL));
      tick();
    end
    #1 check("to_release", 32'(w_vec), 32'(c_V_TOMIS));
    tick();
    idle_inputs();
    #1 check("to_after", 32'(w_vec), 32'(c_V_IDLE));
    check("to_stall_cnt", 32'(stall_cnt), 32'd8);
    check("to_flush_cnt", 32'(flush_cnt), 32'd2);

    for (int i = 0; i < 10; i++) begin
      lu_inputs();
      tick();
    end
    idle_inputs();
    #1 check("stall_sat", 32'(stall_cnt), 32'd15);
    for (int i = 0; i < 16; i++) begin
      mispred = 1'b1;
      tick();
    end
    idle_inputs();
    #1 check("flush_sat", 32'(flush_cnt), 32'd15);

    req = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1 check("rst_in_wait", 32'(w_vec), 32'(c_V_RST));
    tick();
    rst = 1'b0; req = 1'b0;
    #1 check("rst_wait_run", 32'(w_vec), 32'(c_V_IDLE));
    check("rst_wait_stall", 32'(stall_cnt), 32'd0);
    check("rst_wait_flush", 32'(flush_cnt), 32'd0);
    tick();
    #1 check("rst_wait_noerr", 32'(mem_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the five-stage RV32 pipeline with always-taken branch prediction. It generates every pipeline-register enable and flush from three events: memory-stage wait, EX-stage branch mispredict, and load-use hazard. It also bounds memory waits with a timeout and keeps stall/flush performance counters. It sits beside the datapath, and its outputs drive the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.

## Interface
Parameters:
- MEM_TIMEOUT, 255: total stall cycles allowed for one memory access before a forced release; must be ≥2.
- CNT_W, 32: width of the performance counters.

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- id_rs1_addr_i, id_rs2_addr_i  in  5  source registers of the instruction in ID
- id_uses_rs1_i, id_uses_rs2_i  in  1  ID instruction reads rs1 / rs2
- ex_rd_addr_i  in  5  destination register of the instruction in EX
- ex_rd_wren_i, ex_is_load_i  in  1  EX instruction writes rd / is a load
- ex_mispred_i  in  1  branch resolved in EX disagrees with the prediction (redirect target supplied by the branch unit)
- mem_req_i  in  1  MEM stage holds a valid load/store
- mem_ack_i  in  1  LSU completes the access this cycle
- pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o  out  1  register load enables
- if_id_flush_o, id_ex_flush_o, mem_wb_flush_o  out  1  clear the register to a bubble at the next edge
- mem_err_o  out  1  one-cycle pulse on a memory timeout
- stall_cnt_o, flush_cnt_o  out  CNT_W  performance counters

## Operation
- Control states: RUN and MEM_WAIT. A wait counter wait_cnt is also kept.
- Load-use hazard (lu): ex_is_load_i & ex_rd_wren_i & ex_rd_addr_i≠0 & ((id_uses_rs1_i & rs1==rd) | (id_uses_rs2_i & rs2==rd)).
- Event priority, highest first: memory stall, then mispredict, then load-use.
- Memory stall is active when:
  - in RUN, mem_req_i & ~mem_ack_i holds; or
  - in MEM_WAIT, ~mem_ack_i holds and wait_cnt≠MEM_TIMEOUT.
- Memory stall response: pc/if_id/id_ex/ex_mem enables = 0; mem_wb_en_o=1 and mem_wb_flush_o=1 (bubble into WB).
- Transitions and wait_cnt updates:
  - RUN → MEM_WAIT on mem_req_i & ~mem_ack_i; wait_cnt←1.
  - In MEM_WAIT, on mem_ack_i: release → RUN, wait_cnt←0.
  - In MEM_WAIT, on wait_cnt==MEM_TIMEOUT: forced release, mem_err_o=1, mem_wb_flush_o=1 (failed access squashed) → RUN.
  - Otherwise in MEM_WAIT: stay, wait_cnt++.
- Mispredict (no memory stall): all enables = 1; if_id_flush_o=1 and id_ex_flush_o=1.
- Load-use (no memory stall, no mispredict): pc_en_o=0, if_id_en_o=0, id_ex_en_o=1, id_ex_flush_o=1; ex_mem and mem_wb enables = 1.
  - The bubble clears ex_is_load_i the next cycle, so the stall is exactly one cycle.
- Idle: all enables = 1, all flushes = 0.
- Invariant: any flush output = 1 implies the matching enable = 1.
- A mispredict during a memory stall is deferred, not lost: ID/EX and EX/MEM are frozen, so ex_mispred_i stays high and takes effect on the release cycle. The forced-release cycle is handled the same way as a normal release.
- stall_cnt_o increments on every non-reset cycle with pc_en_o=0. flush_cnt_o increments on every cycle with if_id_flush_o=1. Both saturate at 2^CNT_W−1.

## Timing
- All enable, flush and mem_err_o outputs are combinational from inputs, state and wait_cnt, and valid in the same cycle. State, wait_cnt and the counters update at posedge clk_i.
- Memory-stall length: a never-acked access produces exactly MEM_TIMEOUT stall cycles, then one release cycle with mem_err_o=1.
- An ack in the same cycle as mem_req_i (RUN) produces zero stall cycles.
- While rst_i=1:
  - all *_en_o=1 and all *_flush_o=1, so every register clears;
  - mem_err_o=0.
- At the first edge with rst_i=1: state←RUN, wait_cnt←0, stall_cnt_o←0, flush_cnt_o←0.
- A reset during MEM_WAIT abandons the wait with no mem_err_o pulse.

## Structure
- Package pipe_ctrl_pkg holds:
  - the state enum (RUN, MEM_WAIT);
  - a packed struct bundling the five enables and three flushes;
  - constant REG_X0=5'd0.
- Sub-module load_use_detect is the purely combinational hazard compare, producing lu. It is reused by the forwarding unit tests.

## Test plan
- lw x5 in EX with ex_rd_wren_i=1, add x6,x5,x1 in ID (id_uses_rs1_i=1) → one cycle: pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1; next cycle with ex_is_load_i=0 → all enables 1; stall_cnt_o=1.
- Same case but ex_rd_addr_i=0 → no stall.
- ex_mispred_i=1 with lu=1 → if_id_flush_o=1, id_ex_flush_o=1, pc_en_o=1; flush_cnt_o+1, stall_cnt_o unchanged.
- mem_req_i=1 with mem_ack_i after 3 cycles → exactly 3 cycles with ex_mem_en_o=0 and mem_wb_flush_o=1; ack cycle has all enables 1; state returns to RUN.
- MEM_TIMEOUT=4, mem_req_i=1, ack never → 4 stall cycles, then 1 cycle with mem_err_o=1 and mem_wb_flush_o=1; ex_mispred_i held high across the wait → flush asserted on the release cycle.
- Counters forced near saturation with CNT_W=4 → stall_cnt_o holds at 15. rst_i asserted in MEM_WAIT → next cycle RUN, counters 0, no mem_err_o.
